kbd_ctrl: RTL

//  Sequences the ps2_keyboard receive FIFO: pops scan-code bytes via the nextdata_n handshake.

---
 rtl/kbd_pkg.sv | 14 +
 rtl/kbd_sc2ascii.sv | 53 +++++
 rtl/kbd_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/kbd_pkg.sv
// Shared constants and state encoding for the PS/2 keyboard controller.
// The prefix bytes come from PS/2 scan-code set 2.
package kbd_pkg;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_POP    = 2'd1,
        ST_SETTLE = 2'd2
    } state_e;

endpackage

// File: rtl/kbd_sc2ascii.sv
// Purely combinational translation of a set-2 scan code to ASCII.
// Letters come out uppercase. Unmapped codes return 0x00.
module kbd_sc2ascii (
    input  logic [7:0] sc_i,
    output logic [7:0] ascii_o
);

    always_comb begin
        ascii_o = 8'h00;
        case (sc_i)
            8'h1C: ascii_o = 8'h41; // A
            8'h32: ascii_o = 8'h42;
            8'h21: ascii_o = 8'h43;
            8'h23: ascii_o = 8'h44;
            8'h24: ascii_o = 8'h45;
            8'h2B: ascii_o = 8'h46;
            8'h34: ascii_o = 8'h47;
            8'h33: ascii_o = 8'h48;
            8'h43: ascii_o = 8'h49;
            8'h3B: ascii_o = 8'h4A;
            8'h42: ascii_o = 8'h4B;
            8'h4B: ascii_o = 8'h4C;
            8'h3A: ascii_o = 8'h4D;
            8'h31: ascii_o = 8'h4E;
            8'h44: ascii_o = 8'h4F;
            8'h4D: ascii_o = 8'h50;
            8'h15: ascii_o = 8'h51;
            8'h2D: ascii_o = 8'h52;
            8'h1B: ascii_o = 8'h53;
            8'h2C: ascii_o = 8'h54;
            8'h3C: ascii_o = 8'h55;
            8'h2A: ascii_o = 8'h56;
            8'h1D: ascii_o = 8'h57;
            8'h22: ascii_o = 8'h58;
            8'h35: ascii_o = 8'h59;
            8'h1A: ascii_o = 8'h5A; // Z
            8'h45: ascii_o = 8'h30; // 0
            8'h16: ascii_o = 8'h31;
            8'h1E: ascii_o = 8'h32;
            8'h26: ascii_o = 8'h33;
            8'h25: ascii_o = 8'h34;
            8'h2E: ascii_o = 8'h35;
            8'h36: ascii_o = 8'h36;
            8'h3D: ascii_o = 8'h37;
            8'h3E: ascii_o = 8'h38;
            8'h46: ascii_o = 8'h39; // 9
            8'h29: ascii_o = 8'h20; // space
            8'h5A: ascii_o = 8'h0D; // enter
            default: ascii_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/kbd_ctrl.sv
// Drains the ps2_keyboard FIFO one byte at a time and tracks the held key.
// It also counts distinct presses and presents the held key as ASCII.
module kbd_ctrl
    import kbd_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter bit COUNT_REPEAT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       kb_data,
    input  logic             kb_ready,
    input  logic             kb_overflow,
    output logic             kb_nextdata_n,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_valid,
    output logic [7:0]       key_ascii,
    output logic [CNT_W-1:0] press_cnt,
    output logic             err_ovf,
    output state_e           dbg_state
);

    state_e           state_q, state_d;
    logic [7:0]       byte_q, byte_d;
    logic             nextdata_q, nextdata_d;
    logic [7:0]       code_q, code_d;
    logic             ext_q, ext_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             brk_pend_q, brk_pend_d;
    logic             ext_pend_q, ext_pend_d;
    logic             ovf_q, ovf_d;
    logic             same_key;
    logic [7:0]       ascii_raw;

    // The incoming key matches the held one only when the prefix state matches as well.
    assign same_key = valid_q && (ext_pend_q == ext_q) && (byte_q == code_q);

    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        nextdata_d = nextdata_q;
        code_d     = code_q;
        ext_d      = ext_q;
        valid_d    = valid_q;
        cnt_d      = cnt_q;
        brk_pend_d = brk_pend_q;
        ext_pend_d = ext_pend_q;
        ovf_d      = ovf_q | kb_overflow;

        case (state_q)
            ST_IDLE: begin
                if (kb_ready) begin
                    byte_d     = kb_data;
                    nextdata_d = 1'b0;
                    state_d    = ST_POP;
                end
            end
            ST_POP: begin
                nextdata_d = 1'b1;
                state_d    = ST_SETTLE;
                if (byte_q == SC_EXT) begin
                    ext_pend_d = 1'b1;
                end else if (byte_q == SC_BREAK) begin
                    brk_pend_d = 1'b1;
                end else if (brk_pend_q) begin
                    if (same_key) begin
                        valid_d = 1'b0;
                    end
                    brk_pend_d = 1'b0;
                    ext_pend_d = 1'b0;
                end else begin
                    if (!same_key) begin
                        code_d  = byte_q;
                        ext_d   = ext_pend_q;
                        valid_d = 1'b1;
                        cnt_d   = cnt_q + 1'b1;
                    end else if (COUNT_REPEAT) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    ext_pend_d = 1'b0;
                end
            end
            // Gives the FIFO one cycle to drop kb_ready after the pop.
            ST_SETTLE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            byte_q     <= 8'h00;
            nextdata_q <= 1'b1;
            code_q     <= 8'h00;
            ext_q      <= 1'b0;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
            brk_pend_q <= 1'b0;
            ext_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            nextdata_q <= nextdata_d;
            code_q     <= code_d;
            ext_q      <= ext_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
            brk_pend_q <= brk_pend_d;
            ext_pend_q <= ext_pend_d;
            ovf_q      <= ovf_d;
        end
    end

    kbd_sc2ascii u_sc2ascii (
        .sc_i    (code_q),
        .ascii_o (ascii_raw)
    );

    assign kb_nextdata_n = nextdata_q;
    assign key_code      = code_q;
    assign key_ext       = ext_q;
    assign key_valid     = valid_q;
    assign key_ascii     = ext_q ? 8'h00 : ascii_raw;
    assign press_cnt     = cnt_q;
    assign err_ovf       = ovf_q;
    assign dbg_state     = state_q;

endmodule
